// File: rtl/mem_arb_pkg.sv
// Shared defaults, FSM states, port ids and response flags for the
// two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF    = 6;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned MEM_DEPTH_DEF = 50;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  typedef struct packed {
    logic ack;
    logic err;
  } rsp_flags_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-granted pointer moves only when a
// grant is actually taken (advance_i).
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_valid_c,
  output port_e      gnt_id_c
);

  port_e last_q, last_d;

  // On a tie the port that was not granted last wins.
  always_comb begin
    gnt_valid_c = |req_i;
    gnt_id_c    = PORT_IF;
    if (req_i[1] && (!req_i[0] || (last_q == PORT_IF))) begin
      gnt_id_c = PORT_DM;
    end
    last_d = last_q;
    if (advance_i && gnt_valid_c) begin
      last_d = gnt_id_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_DM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch and a data port onto one single-ported
// memory: IDLE samples/latches, ISSUE strobes, RESP acks.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic              if_we,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] if_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  port_e             port_q, port_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  rsp_flags_t        if_rsp_q, if_rsp_d;
  rsp_flags_t        dm_rsp_q, dm_rsp_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] dm_hold_q, dm_hold_d;

  logic              gnt_valid_c;
  port_e             gnt_id_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              sel_oor_c;
  logic              rd_done_c;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       ({dm_req, if_req}),
    .advance_i   (state_q == ST_IDLE),
    .gnt_valid_c (gnt_valid_c),
    .gnt_id_c    (gnt_id_c)
  );

  // Winner's request fields and range check.
  always_comb begin
    sel_we_c    = (gnt_id_c == PORT_DM) ? dm_we    : if_we;
    sel_addr_c  = (gnt_id_c == PORT_DM) ? dm_addr  : if_addr;
    sel_wdata_c = (gnt_id_c == PORT_DM) ? dm_wdata : if_wdata;
    sel_oor_c   = (32'(sel_addr_c) >= MEM_DEPTH);
    rd_done_c   = (state_q == ST_RESP) && !we_q && !oor_q;
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    oor_d       = oor_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    if_rsp_d    = '0;
    dm_rsp_d    = '0;
    if_hold_d   = if_hold_q;
    dm_hold_d   = dm_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          port_d  = gnt_id_c;
          we_d    = sel_we_c;
          addr_d  = sel_addr_c;
          wdata_d = sel_wdata_c;
          oor_d   = sel_oor_c;
          // Out-of-range requests bypass the memory entirely.
          if (sel_oor_c) begin
            state_d = ST_RESP;
            if (gnt_id_c == PORT_DM) dm_rsp_d = '{ack: 1'b1, err: 1'b1};
            else                     if_rsp_d = '{ack: 1'b1, err: 1'b1};
          end else begin
            state_d     = ST_ISSUE;
            mem_read_d  = !sel_we_c;
            mem_write_d = sel_we_c;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        if (port_q == PORT_DM) dm_rsp_d = '{ack: 1'b1, err: 1'b0};
        else                   if_rsp_d = '{ack: 1'b1, err: 1'b0};
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (rd_done_c) begin
          if (port_q == PORT_DM) dm_hold_d = mem_rdata;
          else                   if_hold_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_IF;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if_rsp_q    <= '0;
      dm_rsp_q    <= '0;
      if_hold_q   <= '0;
      dm_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      if_rsp_q    <= if_rsp_d;
      dm_rsp_q    <= dm_rsp_d;
      if_hold_q   <= if_hold_d;
      dm_hold_q   <= dm_hold_d;
    end
  end

  // Read data is passed straight from memory in RESP, then held.
  assign if_rdata  = (rd_done_c && (port_q == PORT_IF)) ? mem_rdata : if_hold_q;
  assign dm_rdata  = (rd_done_c && (port_q == PORT_DM)) ? mem_rdata : dm_hold_q;
  assign if_ack    = if_rsp_q.ack;
  assign if_err    = if_rsp_q.err;
  assign dm_ack    = dm_rsp_q.ack;
  assign dm_err    = dm_rsp_q.err;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts
// strobes and acks; a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 50;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_we, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] if_wdata, dm_wdata, if_rdata, dm_rdata;
  logic          if_ack, if_err, dm_ack, dm_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write, mem_read;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  typedef struct { int cyc; bit port; bit err; logic [DW-1:0] rdata; } ack_t;
  typedef struct { int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } stb_t;

  ack_t ack_q[$];
  stb_t stb_q[$];
  int   cyc = 0;
  bit   armed = 0, rst_seen = 0, end_req = 0, done = 0;
  int   n_vec = 0, n_mis = 0, n_to = 0;
  logic [DW-1:0] last_rd [2];

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 0) return 32'h00A11820;
    return 32'h1234_5678 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  // Memory block: registered read, no reset.
  initial begin
    logic [DW-1:0] mem_env [DEPTH];
    for (int i = 0; i < int'(DEPTH); i++) mem_env[i] = init_val(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_write && (int'(mem_addr) < int'(DEPTH))) mem_env[mem_addr] <= mem_wdata;
      if (mem_read && (int'(mem_addr) < int'(DEPTH))) mem_rdata <= mem_env[mem_addr];
    end
  end

  // Reference model: one transaction per arbitration slot, latency by arithmetic.
  initial begin
    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] hold [2];
    bit            p, last, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            busy;
    for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = init_val(i);
    hold[0] = '0; hold[1] = '0; last = 1'b1; busy = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        ack_q.delete(); stb_q.delete();
        busy = 0; last = 1'b1; hold[0] = '0; hold[1] = '0;
        rst_seen = 1; armed = 1;
      end else begin
        rst_seen = 0;
        if (busy > 0) busy--;
        else if (armed && (if_req || dm_req)) begin
          p     = (if_req && dm_req) ? !last : dm_req;
          last  = p;
          we    = p ? dm_we    : if_we;
          addr  = p ? dm_addr  : if_addr;
          wdata = p ? dm_wdata : if_wdata;
          if (int'(addr) >= int'(DEPTH)) begin
            ack_q.push_back('{cyc, p, 1'b1, hold[p]});
            busy = 1;
          end else begin
            stb_q.push_back('{cyc, we, addr, wdata});
            if (we) mdl_mem[addr] = wdata;
            else    hold[p] = mdl_mem[addr];
            ack_q.push_back('{cyc + 1, p, 1'b0, hold[p]});
            busy = 2;
          end
        end
      end
    end
  end

  // Monitor: every cycle either a predicted event or quiet outputs.
  always @(negedge clk) begin
    ack_t a;
    stb_t s;
    if (armed) begin
      if (rst_seen) begin
        chk("reset_flags", 64'({if_ack, dm_ack, if_err, dm_err, mem_read, mem_write}), 64'd0);
        chk("reset_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
        last_rd[0] = '0; last_rd[1] = '0;
      end else begin
        if (stb_q.size() > 0 && stb_q[0].cyc == cyc) begin
          s = stb_q.pop_front();
          chk("strobe", 64'({mem_read, mem_write, mem_addr, mem_wdata}),
              64'({!s.we, s.we, s.addr, s.wdata}));
        end else begin
          chk("no_strobe", 64'({mem_read, mem_write}), 64'd0);
        end
        if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
          a = ack_q.pop_front();
          chk("ack_flags", 64'({if_ack, dm_ack, if_err, dm_err}),
              64'({!a.port, a.port, a.err && !a.port, a.err && a.port}));
          chk("ack_rdata", 64'(a.port ? dm_rdata : if_rdata), 64'(a.rdata));
          last_rd[a.port] = a.rdata;
          chk("other_rdata", 64'(a.port ? if_rdata : dm_rdata), 64'(last_rd[!a.port]));
        end else begin
          chk("no_ack", 64'({if_ack, dm_ack, if_err, dm_err}), 64'd0);
          chk("rdata_hold", 64'({if_rdata, dm_rdata}), 64'({last_rd[0], last_rd[1]}));
        end
      end
    end
    if (end_req && !done) begin
      chk("timeouts", 64'(n_to), 64'd0);
      chk("leftover", 64'(ack_q.size() + stb_q.size()), 64'd0);
      done = 1;
    end
  end

  // Hold one request until its ack (bounded), then drop it.
  task automatic drive(input bit p, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, output bit to);
    if (p) begin dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
    else   begin if_req = 1; if_we = we; if_addr = addr; if_wdata = wdata; end
    to = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (p ? dm_ack : if_ack) begin to = 0; break; end
    end
    if (p) dm_req = 0; else if_req = 0;
  endtask

  task automatic rand_port(input bit p, input int n, input int gap_max, output int tos);
    bit to;
    logic [AW-1:0] addr;
    tos = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(50, 63))
                                         : AW'($urandom_range(0, 49));
      drive(p, 1'($urandom_range(0, 1)), addr, $urandom, to);
      tos += int'(to);
    end
  endtask

  initial begin
    bit to, to2;
    int t0, t1;
    reset = 1; if_req = 0; dm_req = 0; if_we = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; if_wdata = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    drive(1'b0, 1'b0, 6'd0, 32'h0, to);             n_to += int'(to);
    drive(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, to);      n_to += int'(to);
    drive(1'b1, 1'b0, 6'd5, 32'h0, to);             n_to += int'(to);
    drive(1'b1, 1'b0, 6'd50, 32'h0, to);            n_to += int'(to);
    // Both ports saturated: grants must alternate.
    fork
      rand_port(1'b0, 4, 0, t0);
      rand_port(1'b1, 4, 0, t1);
    join
    n_to += t0 + t1;
    fork
      rand_port(1'b0, 150, 3, t0);
      rand_port(1'b1, 150, 3, t1);
    join
    n_to += t0 + t1;
    // Reset while an if read is in ISSUE.
    repeat (3) @(negedge clk);
    if_req = 1; if_we = 0; if_addr = 6'd3;
    @(negedge clk);
    reset = 1; if_req = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    fork
      drive(1'b0, 1'b0, 6'd7, 32'h0, to);
      drive(1'b1, 1'b0, 6'd9, 32'h0, to2);
    join
    n_to += int'(to) + int'(to2);
    repeat (8) @(negedge clk);
    end_req = 1;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    if (!done) begin
      $display("FAIL end_handshake: monitor did not complete");
      $fatal(1, "end handshake");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
